// File: rtl/apple_placer_if.sv
// Bundle between the apple placer and its requester/field owner.
// The master side issues requests and supplies the field; the slave side is the placer.
interface apple_placer_if #(
    parameter logic [7:0] SIZE_X     = 8'd10,
    parameter logic [7:0] SIZE_Y     = 8'd10,
    parameter int         FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y) * 3,
    parameter int         SBITS      = $clog2(int'(SIZE_X) * int'(SIZE_Y))
);
    logic                  req;
    logic [SBITS-1:0]      seed;
    logic [FIELD_SIZE-1:0] field;
    logic                  busy;
    logic                  done;
    logic                  no_space;
    logic [SBITS-1:0]      apple_idx;
    logic [7:0]            apple_x;
    logic [7:0]            apple_y;
    logic                  wr_en;
    logic [SBITS-1:0]      wr_idx;
    logic [2:0]            wr_code;

    modport master (
        output req, seed, field,
        input  busy, done, no_space, apple_idx, apple_x, apple_y, wr_en, wr_idx, wr_code
    );

    modport slave (
        input  req, seed, field,
        output busy, done, no_space, apple_idx, apple_x, apple_y, wr_en, wr_idx, wr_code
    );
endinterface

// File: rtl/apple_placer.sv
// Apple placement engine: scans the field downward from a seed (with wrap) and
// writes the apple code into the first empty cell, or reports that none is free.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for req; seed reduced into range on acceptance
//  S_LOAD  | derive x/y of the start cell by repeated subtraction
//  S_SCAN  | test one cell per cycle, stepping down with wrap
//  S_WRITE | write strobe for the chosen cell
//  S_DONE  | completion pulse, no_space if every cell was occupied
module apple_placer #(
    parameter logic [7:0] SIZE_X     = 8'd10,
    parameter logic [7:0] SIZE_Y     = 8'd10,
    parameter int         FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y) * 3,
    parameter int         SBITS      = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
    parameter logic [2:0] APPLE_CODE = 3'd4
) (
    input logic          i_clk,
    input logic          i_rst,
    apple_placer_if.slave bus
);
    localparam int               N      = int'(SIZE_X) * int'(SIZE_Y);
    localparam logic [SBITS-1:0] N_S    = SBITS'(N);
    localparam logic [SBITS-1:0] LAST_S = SBITS'(N - 1);
    localparam logic [7:0]       X_LAST = SIZE_X - 8'd1;
    localparam logic [7:0]       Y_LAST = SIZE_Y - 8'd1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_WRITE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SBITS-1:0] r_ptr;
    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [SBITS-1:0] r_cnt;
    logic             r_fail;
    logic [SBITS-1:0] r_apple_idx;
    logic [7:0]       r_apple_x;
    logic [7:0]       r_apple_y;
    logic [SBITS-1:0] w_start;
    logic [2:0]       w_cell;
    logic             w_empty;

    // A single conditional subtraction suffices because 2^SBITS < 2N.
    assign w_start = (bus.seed >= N_S) ? (bus.seed - N_S) : bus.seed;
    assign w_cell  = bus.field[int'(r_ptr) * 3 +: 3];
    assign w_empty = (w_cell == 3'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req) w_next = S_LOAD;
            S_LOAD:  if (r_x < SIZE_X) w_next = S_SCAN;
            S_SCAN: begin
                if (w_empty)               w_next = S_WRITE;
                else if (r_cnt == LAST_S)  w_next = S_DONE;
            end
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_fail      <= 1'b0;
            r_apple_idx <= '0;
            r_apple_x   <= '0;
            r_apple_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_ptr  <= w_start;
                        r_x    <= 8'(w_start);
                        r_y    <= '0;
                        r_cnt  <= '0;
                        r_fail <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_x >= SIZE_X) begin
                        r_x <= r_x - SIZE_X;
                        r_y <= r_y + 8'd1;
                    end
                end
                S_SCAN: begin
                    if (w_empty) begin
                        r_apple_idx <= r_ptr;
                        r_apple_x   <= r_x;
                        r_apple_y   <= r_y;
                    end else if (r_cnt == LAST_S) begin
                        r_fail <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + SBITS'(1);
                        // Stepping below cell 0 lands on the bottom-right corner.
                        if (r_ptr == '0) begin
                            r_ptr <= LAST_S;
                            r_x   <= X_LAST;
                            r_y   <= Y_LAST;
                        end else begin
                            r_ptr <= r_ptr - SBITS'(1);
                            if (r_x == 8'd0) begin
                                r_x <= X_LAST;
                                r_y <= r_y - 8'd1;
                            end else begin
                                r_x <= r_x - 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.no_space  = (r_state == S_DONE) && r_fail;
    assign bus.wr_en     = (r_state == S_WRITE);
    assign bus.wr_idx    = (r_state == S_WRITE) ? r_apple_idx : '0;
    assign bus.wr_code   = (r_state == S_WRITE) ? APPLE_CODE : 3'd0;
    assign bus.apple_idx = r_apple_idx;
    assign bus.apple_x   = r_apple_x;
    assign bus.apple_y   = r_apple_y;
endmodule

// File: tb/tb_apple_placer.sv
// Bench for apple_placer: directed and random placements checked against a
// wrap-around scan model, plus reset-during-scan and request-handling cases.
module tb_apple_placer;
    localparam int SX = 10;
    localparam int SY = 10;
    localparam int N  = SX * SY;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [2:0] cells [N];
    int         m_idx, m_x, m_y;

    apple_placer_if bus ();

    apple_placer u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) bus.field[i*3 +: 3] = cells[i];
    endtask

    task automatic fill(input logic [2:0] v);
        for (int i = 0; i < N; i++) cells[i] = v;
    endtask

    // One placement: model computes the outcome, the bench observes 130 cycles.
    task automatic place(input string tag, input int seed_v, input int pulse_cyc);
        int start, ys, kk, exp_idx, exp_wr, exp_done;
        bit found;
        int wr_c, done_c, nwr, ndone, wr_i, wr_cd, ns, ax, ay, busy_after;
        start = (seed_v >= N) ? seed_v - N : seed_v;
        ys    = start / SX;
        found = 0;
        kk    = 0;
        for (int k = 0; k < N; k++)
            if (!found && cells[(start - k + N) % N] == 3'd0) begin
                found = 1;
                kk    = k;
            end
        exp_idx  = (start - kk + N) % N;
        exp_wr   = ys + kk + 2;
        exp_done = found ? exp_wr + 1 : ys + 1 + N;
        if (found) begin
            m_idx = exp_idx;
            m_x   = exp_idx % SX;
            m_y   = exp_idx / SX;
        end

        pack();
        @(negedge clk);
        bus.req  = 1'b1;
        bus.seed = 7'(seed_v);
        @(posedge clk);
        wr_c = -1; done_c = -1; nwr = 0; ndone = 0;
        wr_i = 0; wr_cd = 0; ns = 0; ax = 0; ay = 0; busy_after = 1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (c == 0) bus.req = 1'b0;
            if (c == pulse_cyc) begin
                bus.req  = 1'b1;
                bus.seed = 7'($urandom_range(0, 127));
            end else if (c == pulse_cyc + 1) begin
                bus.req = 1'b0;
            end
            if (bus.wr_en) begin
                nwr++; wr_c = c; wr_i = int'(bus.wr_idx); wr_cd = int'(bus.wr_code);
            end
            if (bus.done) begin
                ndone++; done_c = c; ns = int'(bus.no_space);
                ax = int'(bus.apple_x); ay = int'(bus.apple_y);
            end
            if (c == exp_done + 1) busy_after = int'(bus.busy);
        end
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".done_cyc"}, done_c, exp_done);
        chk({tag, ".no_space"}, ns, found ? 0 : 1);
        chk({tag, ".busy_after"}, busy_after, 0);
        if (found) begin
            chk({tag, ".nwr"}, nwr, 1);
            chk({tag, ".wr_cyc"}, wr_c, exp_wr);
            chk({tag, ".wr_idx"}, wr_i, exp_idx);
            chk({tag, ".wr_code"}, wr_cd, 4);
        end else begin
            chk({tag, ".nwr"}, nwr, 0);
        end
        chk({tag, ".apple_x"}, ax, m_x);
        chk({tag, ".apple_y"}, ay, m_y);
        chk({tag, ".apple_idx"}, bus.apple_idx, m_idx);
    endtask

    initial begin
        int d, nwr, ndone;
        int dc [$];
        bus.req  = 1'b0;
        bus.seed = '0;
        fill(3'd0);
        pack();
        m_idx = 0; m_x = 0; m_y = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.no_space", bus.no_space, 0);
        chk("rst.wr_en", bus.wr_en, 0);
        chk("rst.wr_idx", bus.wr_idx, 0);
        chk("rst.wr_code", bus.wr_code, 0);
        chk("rst.apple_idx", bus.apple_idx, 0);
        chk("rst.apple_x", bus.apple_x, 0);
        chk("rst.apple_y", bus.apple_y, 0);
        rst = 1'b0;

        fill(3'd0);
        place("empty57", 57, -1);
        fill(3'd0); cells[57] = 3'd1; cells[56] = 3'd1; cells[55] = 3'd1;
        place("skip3", 57, 2);
        fill(3'd0); cells[0] = 3'd5;
        place("wrap0", 0, -1);
        fill(3'd0);
        place("seed113", 113, 3);
        fill(3'd2);
        place("full", 0, 10);

        for (int r = 0; r < 8; r++) begin
            d = (r == 3) ? 10 : int'($urandom_range(0, 10));
            for (int i = 0; i < N; i++)
                cells[i] = (int'($urandom_range(0, 9)) < d) ? 3'($urandom_range(1, 7)) : 3'd0;
            place("rand", int'($urandom_range(0, 127)), (r % 2 == 0) ? 1 : -1);
        end

        // Reset in the middle of a long (failing) scan.
        fill(3'd2);
        pack();
        @(negedge clk);
        bus.req  = 1'b1;
        bus.seed = 7'd0;
        @(posedge clk);
        nwr = 0; ndone = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (c == 0) bus.req = 1'b0;
            if (c == 20) rst = 1'b1;
            if (c == 21) begin
                chk("midrst.busy", bus.busy, 0);
                chk("midrst.apple_idx", bus.apple_idx, 0);
                rst = 1'b0;
            end
            if (bus.wr_en) nwr++;
            if (bus.done) ndone++;
        end
        chk("midrst.nwr", nwr, 0);
        chk("midrst.ndone", ndone, 0);
        m_idx = 0; m_x = 0; m_y = 0;

        // req held high: re-accepted in the IDLE cycle after each DONE.
        fill(3'd0);
        pack();
        @(negedge clk);
        bus.req  = 1'b1;
        bus.seed = 7'd57;
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 29) bus.req = 1'b0;
            if (c == 9) chk("hold.busy_gap", bus.busy, 0);
            if (bus.done) dc.push_back(c);
        end
        chk("hold.ndone", dc.size(), 3);
        if (dc.size() == 3) begin
            chk("hold.done0", dc[0], 8);
            chk("hold.done1", dc[1], 18);
            chk("hold.done2", dc[2], 28);
        end
        chk("hold.apple_idx", bus.apple_idx, 57);
        chk("hold.busy_end", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
